axil_reg_bridge: RTL and testbench
==================================

AXIL_REG_BRIDGE -- requirements
Module: axil_reg_bridge

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, AXI data width and register width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, register index width.
REQ-003 SHALL have parameter AXI_ADDR_WIDTH, default 10, byte-address width, and AXI_ADDR_WIDTH SHALL equal ADDR_WIDTH+2.
REQ-004 SHALL have ports clk (in, 1, clock) and resetn (in, 1, reset): reset resetn, asynchronous, active-low; clock clk.
REQ-005 SHALL have AXI4-Lite write ports: awaddr (in, AXI_ADDR_WIDTH), awvalid (in, 1), awready (out, 1), wdata (in, DATA_WIDTH), wstrb (in, DATA_WIDTH/8), wvalid (in, 1), wready (out, 1), bresp (out, 2), bvalid (out, 1), bready (in, 1).
REQ-006 SHALL have AXI4-Lite read ports: araddr (in, AXI_ADDR_WIDTH), arvalid (in, 1), arready (out, 1), rdata (out, DATA_WIDTH), rresp (out, 2), rvalid (out, 1), rready (in, 1).
REQ-007 SHALL have register-file write ports: reg_we (out, 1), reg_wdata (out, DATA_WIDTH), reg_waddr (out, ADDR_WIDTH), reg_wready (in, 1).
REQ-008 SHALL have register-file read ports: reg_re (out, 1), reg_raddr (out, ADDR_WIDTH), reg_rdata (in, DATA_WIDTH, valid the cycle after reg_re, held until the next reg_re), reg_rready (in, 1).

Function
REQ-009 Write FSM SHALL have states W_IDLE, W_WRITE, W_RESP; read FSM SHALL have states R_IDLE, R_READ, R_WAIT, R_RESP; both SHALL run independently.
REQ-010 In W_IDLE, awready SHALL be 1 until an AW handshake is latched, and wready SHALL be 1 until a W handshake is latched; AW and W SHALL be accepted in either order or in the same cycle.
REQ-011 Once both AW and W are latched, the write FSM SHALL go to W_WRITE on the next edge; awready and wready SHALL be 0 outside W_IDLE.
REQ-012 The register index SHALL be awaddr[AXI_ADDR_WIDTH-1:2], and araddr[AXI_ADDR_WIDTH-1:2] for reads.
REQ-013 A write is an error if awaddr[1:0]!=0 or wstrb is not all ones.
REQ-014 In W_WRITE, if the write is not an error, reg_we SHALL pulse for exactly one cycle in the first cycle with reg_wready=1, and the FSM SHALL then go to W_RESP with bresp=OKAY (2'b00).
REQ-015 In W_WRITE, if the write is an error, reg_we SHALL NOT assert, and the FSM SHALL go to W_RESP on the next edge with bresp=SLVERR (2'b10).
REQ-016 In W_RESP, bvalid=1 and bresp SHALL hold stable until bready=1; the FSM SHALL then go to W_IDLE.
REQ-017 Best-case write timing: handshake at cycle 0, reg_we at cycle 1, bvalid at cycle 2.
REQ-018 In R_IDLE, arready SHALL be 1; an AR handshake SHALL latch the index and the error flag (araddr[1:0]!=0), then go to R_READ.
REQ-019 In R_READ, a non-error read SHALL pulse reg_re for one cycle when reg_rready=1 and reg_we=0 in that cycle (read-after-write ordering), then go to R_WAIT.
REQ-020 An error read SHALL skip reg_re and go directly to R_RESP with rdata=0 and rresp=SLVERR.
REQ-021 In R_WAIT, the block SHALL register reg_rdata into rdata and set rresp=OKAY, then go to R_RESP.
REQ-022 In R_RESP, rvalid=1 and rdata/rresp SHALL hold stable until rready=1; the FSM SHALL then go to R_IDLE.
REQ-023 Best-case read timing: AR at cycle 0, reg_re at cycle 1, capture at cycle 2, rvalid at cycle 3.
REQ-024 reg_waddr, reg_wdata and reg_raddr SHALL be registered and stable while their enable is asserted.
REQ-025 Each channel SHALL have at most one outstanding transaction, with no pipelining.
REQ-026 Back-to-back transactions: a new AW/W or AR SHALL be accepted in the cycle after the response handshake completes (IDLE re-entered).

Reset
REQ-027 While resetn=0, awready, wready, bvalid, arready, rvalid, reg_we and reg_re SHALL be 0, and bresp, rresp, rdata, reg_wdata, reg_waddr and reg_raddr SHALL be 0; both FSMs SHALL be in IDLE and all latched flags SHALL be cleared.
REQ-028 Reset asserted mid-transaction SHALL abandon the transaction; no reg_we, reg_re, bvalid or rvalid SHALL occur for it after resetn rises.
REQ-029 awready, wready and arready SHALL first be 1 in the first cycle after resetn deasserts.

Verification
REQ-030 AW=0x014 and W=0xDEADBEEF with wstrb=0xF in the same cycle, bready=1 -> reg_we at cycle 1 with reg_waddr=5 and reg_wdata=0xDEADBEEF; bvalid at cycle 2 with bresp=00.
REQ-031 W at cycle 0, AW=0x008 at cycle 3 -> one reg_we with reg_waddr=2; bvalid 2 cycles after the AW handshake.
REQ-032 awaddr=0x00A, or wstrb=0x3 -> no reg_we; bresp=10.
REQ-033 Write 0x12345678 to 0x020, then AR=0x020 with rready held 0 for 4 cycles -> reg_re with reg_raddr=8; rvalid held with rdata=0x12345678 and rresp=00 until rready.
REQ-034 AR issued while the write FSM is in W_WRITE to the same index -> reg_re strictly after reg_we; rdata equals the new data.
REQ-035 resetn pulsed low while in W_RESP and in R_READ -> bvalid=0, no reg_re, all outputs 0; a new transaction completes normally after reset.

Source files
------------

// File: rtl/axil_reg_bridge.sv
// AXI4-Lite slave to simple register-file bridge.
//
// Converts single AXI4-Lite write and read transactions into one-cycle
// register-file strobes. The write and read channels each run their own FSM,
// and each allows one outstanding transaction.
//
// Ports:
//   clk, resetn             clock; asynchronous active-low reset
//   aw*/w*/b*               AXI4-Lite write address, data and response
//   ar*/r*                  AXI4-Lite read address and data/response
//   reg_we/reg_waddr/       register write strobe, word index and data.
//   reg_wdata/reg_wready    reg_wready=1 lets the strobe fire.
//   reg_re/reg_raddr/       register read strobe and word index. reg_rdata is
//   reg_rdata/reg_rready    valid the cycle after reg_re; reg_rready=1 lets the
//                           strobe fire.
//
// Byte addresses are converted to word indices by dropping bits [1:0].
// AXI_ADDR_WIDTH must equal ADDR_WIDTH + 2.

module axil_reg_bridge #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned AXI_ADDR_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      resetn,

  // AXI4-Lite write channels
  input  logic [AXI_ADDR_WIDTH-1:0] awaddr,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/8-1:0]   wstrb,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [1:0]                bresp,
  output logic                      bvalid,
  input  logic                      bready,

  // AXI4-Lite read channels
  input  logic [AXI_ADDR_WIDTH-1:0] araddr,
  input  logic                      arvalid,
  output logic                      arready,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic [1:0]                rresp,
  output logic                      rvalid,
  input  logic                      rready,

  // Register-file write port
  output logic                      reg_we,
  output logic [DATA_WIDTH-1:0]     reg_wdata,
  output logic [ADDR_WIDTH-1:0]     reg_waddr,
  input  logic                      reg_wready,

  // Register-file read port
  output logic                      reg_re,
  output logic [ADDR_WIDTH-1:0]     reg_raddr,
  input  logic [DATA_WIDTH-1:0]     reg_rdata,
  input  logic                      reg_rready
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Write FSM states
  localparam logic [1:0] W_IDLE  = 2'd0;
  localparam logic [1:0] W_WRITE = 2'd1;
  localparam logic [1:0] W_RESP  = 2'd2;

  // Read FSM states
  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_READ = 2'd1;
  localparam logic [1:0] R_WAIT = 2'd2;
  localparam logic [1:0] R_RESP = 2'd3;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------

  // Goes high on the first edge after reset release. The ready outputs are
  // gated with it, so they stay low while in reset.
  logic init_q, init_d;

  logic [1:0]            w_state_q, w_state_d;
  logic                  aw_got_q, aw_got_d;   // AW accepted, waiting for W
  logic                  w_got_q, w_got_d;     // W accepted, waiting for AW
  logic                  aw_err_q, aw_err_d;   // misaligned write address
  logic                  w_err_q, w_err_d;     // partial write strobe
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [1:0]            bresp_q, bresp_d;

  logic [1:0]            r_state_q, r_state_d;
  logic                  r_err_q, r_err_d;     // misaligned read address
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;

  // ---------------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------------

  logic aw_hs;
  logic w_hs;
  logic write_err;
  logic write_pending;

  assign init_d = 1'b1;

  assign awready = init_q & (w_state_q == W_IDLE) & ~aw_got_q;
  assign wready  = init_q & (w_state_q == W_IDLE) & ~w_got_q;
  assign aw_hs   = awvalid & awready;
  assign w_hs    = wvalid & wready;

  assign write_err = aw_err_q | w_err_q;
  // A good write has been accepted but not yet pushed into the register file.
  assign write_pending = (w_state_q == W_WRITE) & ~write_err;

  assign reg_we    = write_pending & reg_wready;
  assign reg_waddr = waddr_q;
  assign reg_wdata = wdata_q;
  assign bvalid    = (w_state_q == W_RESP);
  assign bresp     = bresp_q;

  always_comb begin
    w_state_d = w_state_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    aw_err_d  = aw_err_q;
    w_err_d   = w_err_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    bresp_d   = bresp_q;

    case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_got_d = 1'b1;
          waddr_d  = awaddr[AXI_ADDR_WIDTH-1:2];
          aw_err_d = |awaddr[1:0];
        end
        if (w_hs) begin
          w_got_d = 1'b1;
          wdata_d = wdata;
          w_err_d = ~&wstrb;
        end
        // Address and data may arrive in either order or together.
        if ((aw_got_q | aw_hs) && (w_got_q | w_hs)) begin
          w_state_d = W_WRITE;
          aw_got_d  = 1'b0;
          w_got_d   = 1'b0;
        end
      end

      W_WRITE: begin
        if (write_err) begin
          bresp_d   = RESP_SLVERR;
          w_state_d = W_RESP;
        end else if (reg_wready) begin
          bresp_d   = RESP_OKAY;
          w_state_d = W_RESP;
        end
      end

      W_RESP: begin
        if (bready) begin
          w_state_d = W_IDLE;
        end
      end

      default: begin
        w_state_d = W_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------------

  logic ar_hs;

  assign arready = init_q & (r_state_q == R_IDLE);
  assign ar_hs   = arvalid & arready;

  // Holding off while a good write is pending also covers the reg_we cycle
  // itself, so a read to the same index always returns the new data.
  assign reg_re    = (r_state_q == R_READ) & ~r_err_q & reg_rready & ~write_pending;
  assign reg_raddr = raddr_q;
  assign rvalid    = (r_state_q == R_RESP);
  assign rdata     = rdata_q;
  assign rresp     = rresp_q;

  always_comb begin
    r_state_d = r_state_q;
    r_err_d   = r_err_q;
    raddr_d   = raddr_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;

    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          raddr_d   = araddr[AXI_ADDR_WIDTH-1:2];
          r_err_d   = |araddr[1:0];
          r_state_d = R_READ;
        end
      end

      R_READ: begin
        if (r_err_q) begin
          rdata_d   = '0;
          rresp_d   = RESP_SLVERR;
          r_state_d = R_RESP;
        end else if (reg_re) begin
          r_state_d = R_WAIT;
        end
      end

      // reg_rdata is valid in the cycle after reg_re.
      R_WAIT: begin
        rdata_d   = reg_rdata;
        rresp_d   = RESP_OKAY;
        r_state_d = R_RESP;
      end

      R_RESP: begin
        if (rready) begin
          r_state_d = R_IDLE;
        end
      end

      default: begin
        r_state_d = R_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      init_q    <= 1'b0;
      w_state_q <= W_IDLE;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      aw_err_q  <= 1'b0;
      w_err_q   <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      bresp_q   <= RESP_OKAY;
      r_state_q <= R_IDLE;
      r_err_q   <= 1'b0;
      raddr_q   <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      init_q    <= init_d;
      w_state_q <= w_state_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      aw_err_q  <= aw_err_d;
      w_err_q   <= w_err_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      r_err_q   <= r_err_d;
      raddr_q   <= raddr_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

endmodule

// File: tb/tb_axil_reg_bridge.sv
// Self-checking bench for axil_reg_bridge: table-driven AXI writes and reads
// against a register-file model, with scoreboard queues checked by a monitor
// and hand-written sequences for read-after-write ordering and mid-transaction
// reset.

module tb_axil_reg_bridge;

  localparam int DW  = 32;
  localparam int AW  = 8;
  localparam int AAW = 10;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic [AAW-1:0] awaddr = '0;
  logic           awvalid = 1'b0;
  logic           awready;
  logic [DW-1:0]  wdata = '0;
  logic [3:0]     wstrb = '0;
  logic           wvalid = 1'b0;
  logic           wready;
  logic [1:0]     bresp;
  logic           bvalid;
  logic           bready = 1'b1;
  logic [AAW-1:0] araddr = '0;
  logic           arvalid = 1'b0;
  logic           arready;
  logic [DW-1:0]  rdata;
  logic [1:0]     rresp;
  logic           rvalid;
  logic           rready = 1'b1;
  logic           reg_we;
  logic [DW-1:0]  reg_wdata;
  logic [AW-1:0]  reg_waddr;
  logic           reg_wready = 1'b1;
  logic           reg_re;
  logic [AW-1:0]  reg_raddr;
  logic [DW-1:0]  reg_rdata;
  logic           reg_rready = 1'b1;

  always #5 clk = ~clk;

  axil_reg_bridge #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .AXI_ADDR_WIDTH(AAW)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .awaddr    (awaddr),
    .awvalid   (awvalid),
    .awready   (awready),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .wvalid    (wvalid),
    .wready    (wready),
    .bresp     (bresp),
    .bvalid    (bvalid),
    .bready    (bready),
    .araddr    (araddr),
    .arvalid   (arvalid),
    .arready   (arready),
    .rdata     (rdata),
    .rresp     (rresp),
    .rvalid    (rvalid),
    .rready    (rready),
    .reg_we    (reg_we),
    .reg_wdata (reg_wdata),
    .reg_waddr (reg_waddr),
    .reg_wready(reg_wready),
    .reg_re    (reg_re),
    .reg_raddr (reg_raddr),
    .reg_rdata (reg_rdata),
    .reg_rready(reg_rready)
  );

  // Register-file model: read data appears the cycle after reg_re.
  logic [DW-1:0] regs [256];
  logic [DW-1:0] rf_rdata_q;
  always @(posedge clk) begin
    if (reg_we) regs[reg_waddr] <= reg_wdata;
    if (reg_re) rf_rdata_q <= regs[reg_raddr];
  end
  assign reg_rdata = rf_rdata_q;

  // Scoreboard
  typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct packed { logic [DW-1:0] data; logic [1:0] resp; } rd_t;
  wr_t           wq[$];
  logic [AW-1:0] rq[$];
  logic [1:0]    bq[$];
  rd_t           rdq[$];
  logic [DW-1:0] shadow [256];

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_we = 0, n_re = 0, n_b = 0, n_r = 0;
  int we_cyc = 0, re_cyc = 0, b_cyc = 0, rv_cyc = 0;
  logic rvalid_prev = 1'b0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void fail(string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: compares DUT strobes and responses against the queues.
  initial begin
    wr_t           e;
    rd_t           r;
    logic [AW-1:0] ra;
    logic [1:0]    br;
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (reg_we) begin
          n_we++;
          we_cyc = cyc;
          if (wq.size() == 0) fail("unexpected_reg_we");
          else begin
            e = wq.pop_front();
            check("reg_waddr", 64'(reg_waddr), 64'(e.addr));
            check("reg_wdata", 64'(reg_wdata), 64'(e.data));
          end
        end
        if (reg_re) begin
          n_re++;
          re_cyc = cyc;
          if (rq.size() == 0) fail("unexpected_reg_re");
          else begin
            ra = rq.pop_front();
            check("reg_raddr", 64'(reg_raddr), 64'(ra));
          end
        end
        if (bvalid) begin
          if (bq.size() == 0) fail("unexpected_bvalid");
          else if (bready) begin
            n_b++;
            b_cyc = cyc;
            br = bq.pop_front();
            check("bresp", 64'(bresp), 64'(br));
          end else begin
            check("bresp_hold", 64'(bresp), 64'(bq[0]));
          end
        end
        if (rvalid) begin
          if (!rvalid_prev) rv_cyc = cyc;
          if (rdq.size() == 0) fail("unexpected_rvalid");
          else if (rready) begin
            n_r++;
            r = rdq.pop_front();
            check("rdata", 64'(rdata), 64'(r.data));
            check("rresp", 64'(rresp), 64'(r.resp));
          end else begin
            check("rdata_hold", 64'(rdata), 64'(rdq[0].data));
            check("rresp_hold", 64'(rresp), 64'(rdq[0].resp));
          end
        end
        rvalid_prev = rvalid;
      end else begin
        rvalid_prev = 1'b0;
      end
    end
  end

  task automatic axi_write(input logic [AAW-1:0] addr, input logic [DW-1:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input logic [1:0] exp_resp, input bit chk_t, input bit wait_resp);
    int  t, hs_cyc, nb0, nwe0;
    bit  aw_done, w_done, hs_aw, hs_w;
    wr_t e;
    t = 0; hs_cyc = 0; aw_done = 0; w_done = 0; nb0 = n_b; nwe0 = n_we;
    bq.push_back(exp_resp);
    if (exp_resp == 2'b00) begin
      e.addr = addr[AAW-1:2];
      e.data = data;
      wq.push_back(e);
      shadow[addr[AAW-1:2]] = data;
    end
    awaddr = addr; wdata = data; wstrb = strb;
    while (!(aw_done && w_done)) begin
      awvalid = !aw_done && (t >= aw_dly);
      wvalid  = !w_done && (t >= w_dly);
      @(negedge clk);
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      if (hs_aw || hs_w) hs_cyc = cyc;
      @(posedge clk); #1;
      aw_done = aw_done | hs_aw;
      w_done  = w_done | hs_w;
      t++;
      if (t > 40) begin
        fail("write_handshake_timeout");
        break;
      end
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    if (wait_resp) begin
      t = 0;
      while (n_b == nb0 && t < 40) begin
        @(posedge clk); #1;
        t++;
      end
      check("write_resp_seen", 64'(n_b != nb0), 64'(1));
      if (chk_t) begin
        check("b_latency", 64'(b_cyc - hs_cyc), 64'(2));
        check("we_count", 64'(n_we - nwe0), (exp_resp == 2'b00) ? 64'(1) : 64'(0));
        if (exp_resp == 2'b00) check("we_latency", 64'(we_cyc - hs_cyc), 64'(1));
      end
    end
  endtask

  task automatic axi_read(input logic [AAW-1:0] addr, input int hold, input bit chk_t,
                          input bit wait_resp);
    bit  err, got;
    int  t, ar_cyc, nr0, nre0;
    rd_t r;
    err    = (addr[1:0] != 2'b00);
    r.data = err ? '0 : shadow[addr[AAW-1:2]];
    r.resp = err ? 2'b10 : 2'b00;
    rdq.push_back(r);
    if (!err) rq.push_back(addr[AAW-1:2]);
    nr0 = n_r; nre0 = n_re; ar_cyc = 0;
    rready  = (hold == 0);
    araddr  = addr;
    arvalid = 1'b1;
    t = 0; got = 0;
    do begin
      @(negedge clk);
      got = arready;
      if (got) ar_cyc = cyc;
      t++;
      @(posedge clk); #1;
    end while (!got && t < 40);
    arvalid = 1'b0;
    if (!got) fail("ar_handshake_timeout");
    if (wait_resp) begin
      t = 0;
      while (!rvalid && t < 40) begin
        @(posedge clk); #1;
        t++;
      end
      repeat (hold) @(posedge clk);
      #1 rready = 1'b1;
      t = 0;
      while (n_r == nr0 && t < 40) begin
        @(posedge clk); #1;
        t++;
      end
      check("read_resp_seen", 64'(n_r != nr0), 64'(1));
      if (chk_t) begin
        check("rvalid_latency", 64'(rv_cyc - ar_cyc), err ? 64'(2) : 64'(3));
        check("re_count", 64'(n_re - nre0), err ? 64'(0) : 64'(1));
        if (!err) check("re_latency", 64'(re_cyc - ar_cyc), 64'(1));
      end
    end
    rready = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, 64'({awready, wready, arready, bvalid, rvalid, reg_we, reg_re,
                                bresp, rresp}), 64'(0));
    check({tag, "_data"}, {rdata, reg_wdata}, 64'(0));
    check({tag, "_addr"}, 64'({reg_waddr, reg_raddr}), 64'(0));
  endtask

  typedef struct {
    logic [AAW-1:0] addr;
    logic [DW-1:0]  data;
    logic [3:0]     strb;
    int             aw_dly;
    int             w_dly;
    logic [1:0]     resp;
  } wvec_t;
  wvec_t wvec[6];

  initial begin
    int nwe0, nre0, nb0, nr0;
    wvec[0] = '{10'h014, 32'hDEADBEEF, 4'hF, 0, 0, 2'b00};  // same-cycle AW/W
    wvec[1] = '{10'h008, 32'hCAFEF00D, 4'hF, 3, 0, 2'b00};  // W three cycles before AW
    wvec[2] = '{10'h00A, 32'h11111111, 4'hF, 0, 0, 2'b10};  // misaligned address
    wvec[3] = '{10'h00C, 32'h22222222, 4'h3, 0, 0, 2'b10};  // partial strobe
    wvec[4] = '{10'h020, 32'h12345678, 4'hF, 0, 2, 2'b00};  // AW before W
    wvec[5] = '{10'h3FC, 32'hA5A5A5A5, 4'hF, 1, 1, 2'b00};  // top index

    repeat (3) @(negedge clk);
    check_reset_outputs("reset_initial");
    resetn = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", 64'({awready, wready, arready}), 64'(3'b111));

    for (int i = 0; i < 6; i++) begin
      axi_write(wvec[i].addr, wvec[i].data, wvec[i].strb, wvec[i].aw_dly, wvec[i].w_dly,
                wvec[i].resp, 1, 1);
    end
    for (int i = 0; i < 6; i++) begin
      if (wvec[i].resp == 2'b00) axi_read(wvec[i].addr, 0, 1, 1);
    end
    axi_read(10'h021, 0, 1, 1);  // misaligned read
    axi_read(10'h00A, 0, 1, 1);

    // rvalid held while rready is low for four cycles
    axi_read(10'h020, 4, 1, 1);

    // Read to the same index while the write waits for reg_wready
    reg_wready = 1'b0;
    fork
      axi_write(10'h020, 32'h9ABCDEF0, 4'hF, 0, 0, 2'b00, 0, 1);
      begin
        repeat (2) @(posedge clk);
        #1 axi_read(10'h020, 0, 0, 1);
      end
      begin
        repeat (6) @(posedge clk);
        #1 reg_wready = 1'b1;
      end
    join
    check("raw_order", 64'(re_cyc > we_cyc), 64'(1));

    // Reset while the write sits in W_RESP and the read in R_READ
    bready = 1'b0;
    axi_write(10'h030, 32'h55AA55AA, 4'hF, 0, 0, 2'b00, 0, 0);
    repeat (3) @(posedge clk);
    #1 check("bvalid_in_resp", 64'(bvalid), 64'(1));
    reg_rready = 1'b0;
    axi_read(10'h030, 0, 0, 0);
    @(negedge clk);
    resetn = 1'b0;
    #1 check_reset_outputs("reset_mid");
    wq.delete(); rq.delete(); bq.delete(); rdq.delete();
    nwe0 = n_we; nre0 = n_re; nb0 = n_b; nr0 = n_r;
    @(negedge clk);
    resetn = 1'b1;
    bready = 1'b1;
    reg_rready = 1'b1;
    @(posedge clk); #1;
    check("ready_after_mid_reset", 64'({awready, wready, arready}), 64'(3'b111));
    repeat (8) @(posedge clk);
    #1;
    check("abandoned_we", 64'(n_we - nwe0), 64'(0));
    check("abandoned_re", 64'(n_re - nre0), 64'(0));
    check("abandoned_b", 64'(n_b - nb0), 64'(0));
    check("abandoned_r", 64'(n_r - nr0), 64'(0));
    check("idle_valids", 64'({bvalid, rvalid}), 64'(0));

    axi_write(10'h030, 32'h0BADF00D, 4'hF, 0, 0, 2'b00, 1, 1);
    axi_read(10'h030, 0, 1, 1);

    repeat (3) @(posedge clk);
    #1 check("scoreboard_drained", 64'(wq.size() + rq.size() + bq.size() + rdq.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
